// File: rtl/axil_inst_rd_responder_pkg.sv
// Shared definitions for the instruction-fetch AXI-lite read responder.
package axil_inst_rd_responder_pkg;

  localparam int AXI_RESP_W = 2;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;

  // Width of the per-request wait counter (LATENCY range 0..15).
  localparam int WAIT_W = 4;

  // Response code for a beat given its decode-error flag.
  function automatic logic [AXI_RESP_W-1:0] resp_for(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_req_fifo.sv
// Synchronous request FIFO holding {err, idx} entries between AR acceptance and SRAM issue.
// Pointers carry one extra MSB so full and empty are distinguishable without a separate flag.
module axil_req_fifo #(
  parameter int W          = 13,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [W-1:0]          wdata_i,
  input  logic                  pop_i,
  output logic [W-1:0]          rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Advance read/write pointers on accepted push and pop.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Write the entry storage.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid, so it maps onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axil_inst_rd_responder.sv
// AXI-lite read-only responder for instruction fetch. Accepted AR requests are queued,
// issued in order to a synchronous SRAM after a programmable wait, and returned as R beats
// through a two-stage pipeline (pend stage aligned with SRAM data, then the R output stage).
module axil_inst_rd_responder
  import axil_inst_rd_responder_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
  parameter int          MEM_WORDS  = 4096,
  parameter int          IDX_W      = 12,
  parameter int          DEPTH_LOG2 = 2,
  parameter int          LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [63:0]           s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [AXI_RESP_W-1:0] s_rresp,
  output logic [31:0]           s_rdata,
  output logic                  mem_en,
  output logic [IDX_W-1:0]      mem_idx,
  input  logic [31:0]           mem_rdata
);

  localparam int                  ENTRY_W      = IDX_W + 1;
  localparam logic [63:0]         MEM_END      = MEM_BASE + 64'(MEM_WORDS) * 64'd4;
  localparam logic [IDX_W-1:0]    MEM_BASE_IDX = MEM_BASE[IDX_W+1:2];
  localparam logic [WAIT_W-1:0]   WAIT_RELOAD  = WAIT_W'(LATENCY);
  localparam logic [DEPTH_LOG2:0] CNT_ONE      = (DEPTH_LOG2+1)'(1);

  // Registered state.
  logic                  rst_done_q;
  logic [WAIT_W-1:0]     wait_q,   wait_d;
  logic                  pend_v_q, pend_v_d;
  logic                  pend_err_q, pend_err_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q,  rdata_d;
  logic [AXI_RESP_W-1:0] rresp_q,  rresp_d;

  // Request path.
  logic                  ar_err, ar_push;
  logic [IDX_W-1:0]      ar_idx;
  logic [ENTRY_W-1:0]    head;
  logic                  head_err;
  logic                  fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  pend_move, issue, head_reload;

  // Misaligned or outside [MEM_BASE, MEM_END) in full 64-bit arithmetic, so no wrap-around.
  assign ar_err  = (s_araddr[1:0] != 2'b00) | (s_araddr < MEM_BASE) | (s_araddr >= MEM_END);
  // MEM_BASE is word aligned, so subtracting the word-index fields equals (addr-base)>>2.
  assign ar_idx  = s_araddr[IDX_W+1:2] - MEM_BASE_IDX;

  // Readiness comes only from registered state; no combinational path from s_arvalid.
  assign s_arready = rst_done_q & ~fifo_full;
  assign ar_push   = s_arvalid & s_arready;

  axil_req_fifo #(
    .W          (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ar_push),
    .wdata_i ({ar_err, ar_idx}),
    .pop_i   (issue),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_err  = head[IDX_W];
  assign pend_move = pend_v_q & (~rvalid_q | s_rready);
  assign issue     = ~fifo_empty & (wait_q == '0) & (~pend_v_q | pend_move);

  // Error entries still take their slot in order but never touch the SRAM.
  assign mem_en  = issue & ~head_err;
  assign mem_idx = head[IDX_W-1:0];

  // A new entry becomes head after a pop that leaves something behind, or a push into an empty FIFO.
  assign head_reload = (issue & ((fifo_count > CNT_ONE) | ar_push)) | (ar_push & fifo_empty);

  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  // Next-state for the wait counter, pend stage and R output stage.
  // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    wait_d     = wait_q;
    pend_v_d   = pend_v_q;
    pend_err_d = pend_err_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    if (head_reload) begin
      wait_d = WAIT_RELOAD;
    end else if (!fifo_empty && wait_q != '0) begin
      wait_d = wait_q - 1'b1;
    end

    if (issue) begin
      pend_v_d   = 1'b1;
      pend_err_d = head_err;
    end else if (pend_move) begin
      pend_v_d   = 1'b0;
    end

    // R stage holds while stalled; a pend move refills it in the same cycle as a handshake.
    if (pend_move) begin
      rvalid_d = 1'b1;
      rdata_d  = pend_err_q ? 32'h0 : mem_rdata;
      rresp_d  = resp_for(pend_err_q);
    end else if (s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset discards all in-flight work immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      wait_q     <= WAIT_RELOAD;
      pend_v_q   <= 1'b0;
      pend_err_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= AXI_RESP_OKAY;
    end else begin
      rst_done_q <= 1'b1;
      wait_q     <= wait_d;
      pend_v_q   <= pend_v_d;
      pend_err_q <= pend_err_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_inst_rd_responder.sv
// Directed bench for axil_inst_rd_responder: one instance with LATENCY=0, one with LATENCY=3,
// each with a behavioural synchronous SRAM. R handshakes are logged with cycle stamps.
module tb_axil_inst_rd_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // LATENCY = 0 instance signals
  logic        arvalid, arready, rvalid, rready, mem_en;
  logic [63:0] araddr;
  logic [1:0]  rresp;
  logic [31:0] rdata, mem_rdata;
  logic [11:0] mem_idx;

  // LATENCY = 3 instance signals
  logic        arvalid3, arready3, rvalid3, rready3, mem_en3;
  logic [63:0] araddr3;
  logic [1:0]  rresp3;
  logic [31:0] rdata3, mem_rdata3;
  logic [11:0] mem_idx3;

  axil_inst_rd_responder #(.LATENCY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr),
    .s_rvalid(rvalid), .s_rready(rready), .s_rresp(rresp), .s_rdata(rdata),
    .mem_en(mem_en), .mem_idx(mem_idx), .mem_rdata(mem_rdata)
  );

  axil_inst_rd_responder #(.LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(arvalid3), .s_arready(arready3), .s_araddr(araddr3),
    .s_rvalid(rvalid3), .s_rready(rready3), .s_rresp(rresp3), .s_rdata(rdata3),
    .mem_en(mem_en3), .mem_idx(mem_idx3), .mem_rdata(mem_rdata3)
  );

  // Memory contents; word 4 is fixed, the rest follow a simple pattern.
  function automatic logic [31:0] word_of(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0001);
  endfunction

  logic [31:0] sram [4096];
  always @(posedge clk) begin
    if (mem_en)  mem_rdata  <= sram[mem_idx];
    if (mem_en3) mem_rdata3 <= sram[mem_idx3];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
  } beat_t;

  beat_t beats[$];
  beat_t beats3[$];
  int    mem_en_cnt = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid === 1'b1 && rready === 1'b1)
      beats.push_back('{d: rdata, r: rresp, c: cyc});
    if (rst_n === 1'b1 && rvalid3 === 1'b1 && rready3 === 1'b1)
      beats3.push_back('{d: rdata3, r: rresp3, c: cyc});
    if (mem_en === 1'b1) mem_en_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, n0, e0, acc;
    logic hs;
    logic [63:0] err_addr [3];

    for (int i = 0; i < 4096; i++) sram[i] = word_of(i);
    rst_n = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    arvalid3 = 1'b0; araddr3 = '0; rready3 = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_mem_en",  64'(mem_en),  64'd0);
    rst_n = 1'b1;
    tick();
    check("arready_after_rst",  64'(arready),  64'd1);
    check("arready3_after_rst", 64'(arready3), 64'd1);

    // 1: single read of word 4
    rready = 1'b1;
    n0 = beats.size();
    a = cyc;
    araddr = 64'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t1_mem_en_c1",  64'(mem_en),  64'd1);
    check("t1_mem_idx",    64'(mem_idx), 64'd4);
    check("t1_rvalid_c1",  64'(rvalid),  64'd0);
    tick();
    check("t1_rvalid_c2",  64'(rvalid),  64'd0);
    check("t1_mem_en_c2",  64'(mem_en),  64'd0);
    tick();
    check("t1_rvalid_c3",  64'(rvalid),  64'd1);
    check("t1_rdata",      64'(rdata),   64'hDEAD_BEEF);
    check("t1_rresp",      64'(rresp),   64'd0);
    tick();
    check("t1_rvalid_drop", 64'(rvalid), 64'd0);
    check("t1_nbeats",     64'(beats.size() - n0), 64'd1);
    check("t1_beat_cycle", 64'(beats[n0].c), 64'(a + 3));

    // 2: four back-to-back reads, one beat per cycle
    n0 = beats.size();
    a = cyc;
    for (int i = 0; i < 4; i++) begin
      araddr = 64'h8000_0000 + 64'(4 * i); arvalid = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    repeat (8) tick();
    check("t2_nbeats", 64'(beats.size() - n0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_data%0d", k),  64'(beats[n0+k].d), 64'(word_of(k)));
      check($sformatf("t2_resp%0d", k),  64'(beats[n0+k].r), 64'd0);
      check($sformatf("t2_cycle%0d", k), 64'(beats[n0+k].c), 64'(a + 3 + k));
    end

    // Last word of the window is still valid
    n0 = beats.size();
    araddr = 64'h8000_3FFC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("last_mem_idx", 64'(mem_idx), 64'd4095);
    check("last_mem_en",  64'(mem_en),  64'd1);
    repeat (5) tick();
    check("last_nbeats", 64'(beats.size() - n0), 64'd1);
    check("last_data",   64'(beats[n0].d), 64'(word_of(4095)));
    check("last_resp",   64'(beats[n0].r), 64'd0);

    // 3: below base, misaligned, one past the end -> SLVERR, no SRAM access
    err_addr[0] = 64'h7FFF_FFFC;
    err_addr[1] = 64'h8000_0002;
    err_addr[2] = 64'h8000_4000;
    n0 = beats.size();
    e0 = mem_en_cnt;
    for (int i = 0; i < 3; i++) begin
      araddr = err_addr[i]; arvalid = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    repeat (8) tick();
    check("t3_nbeats", 64'(beats.size() - n0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3_resp%0d", k), 64'(beats[n0+k].r), 64'h2);
      check($sformatf("t3_data%0d", k), 64'(beats[n0+k].d), 64'd0);
    end
    check("t3_mem_en_pulses", 64'(mem_en_cnt - e0), 64'd0);

    // 4: backpressure for 20 cycles with 7 ARs offered
    rready = 1'b0;
    n0 = beats.size();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      arvalid = (acc < 7);
      araddr  = 64'h8000_0020 + 64'(4 * acc);
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      if (hs) acc++;
    end
    check("t4_accepted", 64'(acc),     64'd6);
    check("t4_arready",  64'(arready), 64'd0);
    check("t4_rvalid",   64'(rvalid),  64'd1);
    check("t4_rdata",    64'(rdata),   64'(word_of(8)));
    arvalid = 1'b0;
    repeat (3) tick();
    check("t4_rdata_stable", 64'(rdata), 64'(word_of(8)));
    check("t4_no_beats",     64'(beats.size() - n0), 64'd0);
    a = cyc;
    rready = 1'b1;
    repeat (10) tick();
    check("t4_nbeats", 64'(beats.size() - n0), 64'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_data%0d", k),  64'(beats[n0+k].d), 64'(word_of(8 + k)));
      check($sformatf("t4_cycle%0d", k), 64'(beats[n0+k].c), 64'(a + k));
    end
    check("t4_arready_back", 64'(arready), 64'd1);

    // 5: LATENCY=3, two back-to-back ARs
    rready3 = 1'b1;
    n0 = beats3.size();
    a = cyc;
    araddr3 = 64'h8000_0100; arvalid3 = 1'b1;
    tick();
    araddr3 = 64'h8000_0104;
    tick();
    arvalid3 = 1'b0;
    repeat (14) tick();
    check("t5_nbeats", 64'(beats3.size() - n0), 64'd2);
    check("t5_cycle0", 64'(beats3[n0].c),   64'(a + 6));
    check("t5_data0",  64'(beats3[n0].d),   64'(word_of(64)));
    check("t5_cycle1", 64'(beats3[n0+1].c), 64'(a + 10));
    check("t5_data1",  64'(beats3[n0+1].d), 64'(word_of(65)));

    // 6: asynchronous reset with three requests in flight
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      araddr = 64'h8000_0080 + 64'(4 * i); arvalid = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    repeat (2) tick();
    check("t6_rvalid_before", 64'(rvalid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rvalid_async",  64'(rvalid),  64'd0);
    check("t6_arready_async", 64'(arready), 64'd0);
    check("t6_mem_en_async",  64'(mem_en),  64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    n0 = beats.size();
    rready = 1'b1;
    repeat (10) tick();
    check("t6_no_stale", 64'(beats.size() - n0), 64'd0);
    check("t6_rvalid_idle", 64'(rvalid), 64'd0);
    a = cyc;
    araddr = 64'h8000_0040; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    repeat (5) tick();
    check("t6_nbeats", 64'(beats.size() - n0), 64'd1);
    check("t6_data",   64'(beats[n0].d), 64'(word_of(16)));
    check("t6_resp",   64'(beats[n0].r), 64'd0);
    check("t6_cycle",  64'(beats[n0].c), 64'(a + 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
